// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
// The CSUM state only exists when PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int unsigned LOADER_DEPTH   = 32;
    localparam int unsigned LOADER_ADDR_W  = 5;
    // Largest word count an 8-bit header byte can express.
    localparam int unsigned LOADER_HDR_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_DONE,
        ST_ERR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , ST_CSUM
`endif
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Fills the instruction memory from a byte stream, then releases the core.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// HDR   | accept word count N (1..DEPTH)
// HI    | accept high byte of the current word
// LO    | accept low byte of the current word
// WRITE | one-cycle memory write strobe, advance address
// CSUM  | accept and compare checksum byte (checksum build only)
// DONE  | program loaded, core released (sticky)
// ERR   | load aborted, core held in reset (sticky)
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH  = LOADER_DEPTH,
    parameter int unsigned ADDR_W = LOADER_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       instruction_input,
    output logic              mem_write,
    output logic [ADDR_W-1:0] load_addr,
    output logic              cpu_resetn,
    output logic              done,
    output logic              error
);

    localparam logic [7:0] HDR_LIMIT =
        8'((DEPTH < LOADER_HDR_MAX) ? DEPTH : LOADER_HDR_MAX);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    loader_state_e     state_q, state_d;
    // Counter and N need one extra bit so that N == DEPTH is representable.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       instr_q, instr_d;
    logic              ready_q;
    logic              wr_q;
    logic              done_q;
    logic              err_q;
    logic              xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign xfer    = byte_valid && ready_q;
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        addr_d  = addr_q;
        instr_d = instr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (xfer) begin
                    if (byte_in == 8'd0 || byte_in > HDR_LIMIT) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = byte_in[ADDR_W:0];
                        cnt_d   = '0;
                        addr_d  = '0;
                        state_d = ST_HI;
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = byte_in;
`endif
                end
            end
            ST_HI: begin
                if (xfer) begin
                    instr_d[15:8] = byte_in;
                    state_d       = ST_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d        = csum_q ^ byte_in;
`endif
                end
            end
            ST_LO: begin
                if (xfer) begin
                    instr_d[7:0] = byte_in;
                    state_d      = ST_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d       = csum_q ^ byte_in;
`endif
                end
            end
            ST_WRITE: begin
                cnt_d  = cnt_inc;
                addr_d = addr_q + ADDR_ONE;
                if (cnt_inc == n_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_HI;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ready_q <= state_d inside {ST_HDR, ST_HI, ST_LO, ST_CSUM};
            csum_q  <= csum_d;
`else
            ready_q <= state_d inside {ST_HDR, ST_HI, ST_LO};
`endif
            wr_q    <= (state_d == ST_WRITE);
            done_q  <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_ERR);
        end
    end

    assign byte_ready        = ready_q;
    assign instruction_input = instr_q;
    assign mem_write         = wr_q;
    assign load_addr         = addr_q;
    assign cpu_resetn        = done_q;
    assign done              = done_q;
    assign error             = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized streams against a
// word-level memory model; checksum cases when PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int CS_EXTRA = 1;
`else
    localparam int CS_EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [15:0]       instruction_input;
    logic              mem_write;
    logic [ADDR_W-1:0] load_addr;
    logic              cpu_resetn;
    logic              done;
    logic              error;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .instruction_input (instruction_input),
        .mem_write         (mem_write),
        .load_addr         (load_addr),
        .cpu_resetn        (cpu_resetn),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Instruction memory as the core would see it, plus the expected contents.
    logic [15:0]       dut_mem [DEPTH] = '{default: 16'h0000};
    logic [15:0]       ref_mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr_log [$];
    logic [15:0]       wr_data_log [$];
    int                acc_cnt = 0;

    always @(negedge clk) begin
        if (mem_write) begin
            dut_mem[load_addr] <= instruction_input;
            wr_addr_log.push_back(load_addr);
            wr_data_log.push_back(instruction_input);
        end
        if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, " instr"}, 32'(instruction_input), 32'd0);
        chk({tag, " load_addr"}, 32'(load_addr), 32'd0);
        chk({tag, " cpu_resetn"}, 32'(cpu_resetn), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the last accepted byte.
    task automatic send_bytes(input logic [7:0] s[$], input bit gaps, output bit ok);
        int idx = 0;
        int wait_c = 0;
        bit hs;
        ok = 1'b1;
        while (idx < s.size()) begin
            byte_in    = s[idx];
            byte_valid = !(gaps && ($urandom_range(0, 2) == 0));
            hs         = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                wait_c = 0;
            end else if (++wait_c > 100) begin
                ok = 1'b0;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk);
        t0 = int'($time);
        #1 start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] s[$], input bit gaps, output int lat, output bit ok);
        int t0;
        int wait_c = 0;
        bit sent;
        pulse_start(t0);
        send_bytes(s, gaps, sent);
        ok = sent;
        while (!(done || error)) begin
            @(posedge clk); #1;
            if (++wait_c > 100) begin
                ok = 1'b0;
                break;
            end
        end
        lat = (int'($time) - 1 - t0) / 10;
    endtask

    task automatic do_good(input string tag, input logic [15:0] w[$], input bit gaps, input bit chk_lat);
        logic [7:0] s[$];
        logic [7:0] x;
        int n, lat, lb, ab, bad;
        bit ok;
        n = w.size();
        s.push_back(8'(n));
        x = 8'(n);
        for (int k = 0; k < n; k++) begin
            s.push_back(w[k][15:8]);
            s.push_back(w[k][7:0]);
            x = x ^ w[k][15:8] ^ w[k][7:0];
            ref_mem[k] = w[k];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        lb = wr_addr_log.size();
        ab = acc_cnt;
        run_load(s, gaps, lat, ok);
        chk({tag, " no_timeout"}, 32'(ok), 32'd1);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " cpu_resetn"}, 32'(cpu_resetn), 32'd1);
        chk({tag, " byte_ready_idle"}, 32'(byte_ready), 32'd0);
        chk({tag, " writes"}, 32'(wr_addr_log.size() - lb), 32'(n));
        bad = 0;
        for (int k = 0; k < n && lb + k < wr_addr_log.size(); k++)
            if (int'(wr_addr_log[lb + k]) != k || wr_data_log[lb + k] !== w[k]) bad++;
        chk({tag, " write_seq_errs"}, 32'(bad), 32'd0);
        bad = 0;
        for (int k = 0; k < DEPTH; k++)
            if (dut_mem[k] !== ref_mem[k]) bad++;
        chk({tag, " mem_errs"}, 32'(bad), 32'd0);
        chk({tag, " bytes_accepted"}, 32'(acc_cnt - ab), 32'(s.size()));
        chk({tag, " load_addr_end"}, 32'(load_addr), 32'(n % DEPTH));
        if (chk_lat) chk({tag, " latency"}, 32'(lat), 32'(1 + 3 * n + CS_EXTRA));
    endtask

    task automatic do_bad(input string tag, input logic [7:0] s[$]);
        int lat, lb;
        bit ok;
        lb = wr_addr_log.size();
        run_load(s, 1'b0, lat, ok);
        chk({tag, " no_timeout"}, 32'(ok), 32'd1);
        chk({tag, " error"}, 32'(error), 32'd1);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " cpu_resetn"}, 32'(cpu_resetn), 32'd0);
        chk({tag, " writes"}, 32'(wr_addr_log.size() - lb), 32'd0);
    endtask

    function automatic void rand_words(input int n, output logic [15:0] w[$]);
        w = {};
        for (int k = 0; k < n; k++) w.push_back(16'($urandom));
    endfunction

    initial begin
        logic [15:0] w[$];
        logic [7:0]  s[$];
        int  lb, t0, wait_c;
        bit  ok;

        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("idle");

        w = '{16'h1234, 16'hABCD};
        do_good("n2_b2b", w, 1'b0, 1'b1);

        s = '{8'h00};
        do_bad("hdr_00", s);
        s = '{8'h21};
        do_bad("hdr_21", s);

        w = {};
        for (int k = 0; k < DEPTH; k++) w.push_back(16'(k));
        do_good("n32_b2b", w, 1'b0, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h12, 8'h34, 8'h27};
        lb = wr_addr_log.size();
        run_load(s, 1'b0, t0, ok);
        ref_mem[0] = 16'h1234;
        chk("csum_good done", 32'(done), 32'd1);
        chk("csum_good error", 32'(error), 32'd0);
        chk("csum_good mem0", 32'(dut_mem[0]), 32'h1234);
        s = '{8'h01, 8'h12, 8'h34, 8'h00};
        run_load(s, 1'b0, t0, ok);
        chk("csum_bad error", 32'(error), 32'd1);
        chk("csum_bad cpu_resetn", 32'(cpu_resetn), 32'd0);
        chk("csum_bad writes", 32'(wr_addr_log.size() - lb), 32'd2);
`endif

        for (int i = 0; i < 6; i++) begin
            rand_words($urandom_range(1, DEPTH), w);
            do_good($sformatf("rand_gap%0d", i), w, 1'b1, 1'b0);
        end

        // Abort after the first word lands; that word stays in memory.
        rand_words(4, w);
        s = '{8'h04, w[0][15:8], w[0][7:0]};
        lb = wr_addr_log.size();
        pulse_start(t0);
        send_bytes(s, 1'b0, ok);
        wait_c = 0;
        while (wr_addr_log.size() <= lb && wait_c < 20) begin
            @(posedge clk); #1;
            wait_c++;
        end
        chk("abort first_write", 32'(wr_addr_log.size() - lb), 32'd1);
        ref_mem[0] = w[0];
        resetn = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        chk("abort idle byte_ready", 32'(byte_ready), 32'd0);
        chk("abort idle cpu_resetn", 32'(cpu_resetn), 32'd0);
        rand_words($urandom_range(1, DEPTH), w);
        do_good("after_abort", w, 1'b1, 1'b0);

        rand_words($urandom_range(1, DEPTH), w);
        do_good("rand_b2b", w, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
